// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Register-file write-back arbiter. Single-cycle ALU results always own the
// write port. Long-latency results (load/mult/div) wait in a small FIFO and
// drain through the port whenever the ALU is not writing. Hazard outputs
// tell decode whether a queued write is still pending to one of its sources.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a long-latency result that arrives while the queue is
//   empty and the ALU is not writing goes straight to the register file in
//   the same cycle instead of being enqueued.
//
// Parameters
//   DEPTH      queue entries (2, 4 or 8)
// Ports
//   clk        clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   alu_valid  ALU result present this cycle (never stalled)
//   alu_rd     ALU destination register
//   alu_wd     ALU result data
//   lng_valid  long-latency result offered
//   lng_ready  queue can accept a long-latency result this cycle
//   lng_rd     long-latency destination register
//   lng_wd     long-latency result data
//   rf_wr      register-file write enable
//   rf_a3      register-file write address
//   rf_wd      register-file write data
//   chk_a1/2   source registers of the instruction in decode
//   hit1/2     a queued write is pending to chk_a1 / chk_a2
//   q_count    number of valid queue entries
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_wd,
    input  logic                       lng_valid,
    output logic                       lng_ready,
    input  logic [4:0]                 lng_rd,
    input  logic [31:0]                lng_wd,
    output logic                       rf_wr,
    output logic [4:0]                 rf_a3,
    output logic [31:0]                rf_wd,
    input  logic [4:0]                 chk_a1,
    input  logic [4:0]                 chk_a2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_rdMem [DEPTH];
    logic [31:0]   r_wdMem [DEPTH];

    logic w_aluWr;
    logic w_xfer;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_hit1;
    logic w_hit2;

    // Ready depends only on the registered count, so a full queue refuses a
    // push even when it pops in the same cycle. Forced low during reset.
    assign lng_ready = rst_n && (r_count != CW'(DEPTH));
    assign w_xfer    = lng_valid && lng_ready;
    assign w_aluWr   = alu_valid && (alu_rd != 5'd0);
    assign w_pop     = !w_aluWr && (r_count != '0);

`ifdef WB_BYPASS_EN
    assign w_bypass  = w_xfer && (lng_rd != 5'd0) && !w_aluWr && (r_count == '0);
`else
    assign w_bypass  = 1'b0;
`endif

    // Writes to x0 are acknowledged but never stored.
    assign w_push    = w_xfer && (lng_rd != 5'd0) && !w_bypass;

    assign q_count   = r_count;

    // Write-port priority: ALU first, then the queue head, then the bypass
    // path. Everything is zero while reset is held.
    always_comb begin
        rf_wr = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (rst_n) begin
            if (w_aluWr) begin
                rf_wr = 1'b1;
                rf_a3 = alu_rd;
                rf_wd = alu_wd;
            end else if (r_count != '0) begin
                rf_wr = 1'b1;
                rf_a3 = r_rdMem[r_head];
                rf_wd = r_wdMem[r_head];
            end else if (w_bypass) begin
                rf_wr = 1'b1;
                rf_a3 = lng_rd;
                rf_wd = lng_wd;
            end
        end
    end

    // An entry is live when its distance from the head (mod DEPTH) is below
    // the count. The entry being accepted this cycle is not yet counted,
    // while the head being popped still is until the edge.
    always_comb begin
        logic [PW-1:0] off;
        off    = '0;
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - r_head;
            if ({1'b0, off} < r_count) begin
                if (r_rdMem[i] == chk_a1) w_hit1 = 1'b1;
                if (r_rdMem[i] == chk_a2) w_hit2 = 1'b1;
            end
        end
    end

    assign hit1 = rst_n && (chk_a1 != 5'd0) && w_hit1;
    assign hit2 = rst_n && (chk_a2 != 5'd0) && w_hit2;

    // Pointers and count; power-of-two DEPTH makes pointer wrap natural.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)  r_head <= r_head + PW'(1);
            if (w_push) r_tail <= r_tail + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rdMem[r_tail] <= lng_rd;
            r_wdMem[r_tail] <= lng_wd;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. Inputs are driven on the falling edge,
// outputs are compared 1ns later against a queue-based reference model, and
// the model advances on the rising edge. Directed steps come first, then a
// randomized run. Build with +define+WB_BYPASS_EN to exercise the bypass.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluWd;
    logic        lngValid;
    logic        lngReady;
    logic [4:0]  lngRd;
    logic [31:0] lngWd;
    logic        rfWr;
    logic [4:0]  rfA3;
    logic [31:0] rfWd;
    logic [4:0]  chkA1;
    logic [4:0]  chkA2;
    logic        hit1;
    logic        hit2;
    logic [$clog2(DEPTH):0] qCount;

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (aluValid),
        .alu_rd    (aluRd),
        .alu_wd    (aluWd),
        .lng_valid (lngValid),
        .lng_ready (lngReady),
        .lng_rd    (lngRd),
        .lng_wd    (lngWd),
        .rf_wr     (rfWr),
        .rf_a3     (rfA3),
        .rf_wd     (rfWd),
        .chk_a1    (chkA1),
        .chk_a2    (chkA2),
        .hit1      (hit1),
        .hit2      (hit2),
        .q_count   (qCount)
    );

    // Free-running 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // True when the model holds a pending write to register r
    function automatic logic modelHit(input logic [4:0] r);
        logic h;
        h = 1'b0;
        if (r != 5'd0)
            foreach (mq[k]) if (mq[k].rd == r) h = 1'b1;
        return h;
    endfunction

    function automatic logic modelBypass();
`ifdef WB_BYPASS_EN
        return (mq.size() == 0) && !(aluValid && aluRd != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against what the model says for current inputs
    task automatic checkOutput();
        logic        eWr;
        logic [4:0]  eA3;
        logic [31:0] eWd;
        logic        eReady;
        eWr = 1'b0; eA3 = 5'd0; eWd = 32'd0;
        eReady = rst_n && (mq.size() != DEPTH);
        if (rst_n) begin
            if (aluValid && aluRd != 5'd0) begin
                eWr = 1'b1; eA3 = aluRd; eWd = aluWd;
            end else if (mq.size() > 0) begin
                eWr = 1'b1; eA3 = mq[0].rd; eWd = mq[0].wd;
            end else if (modelBypass() && lngValid && eReady && lngRd != 5'd0) begin
                eWr = 1'b1; eA3 = lngRd; eWd = lngWd;
            end
        end
        checkVal("rf_wr",     32'(rfWr),     32'(eWr));
        checkVal("rf_a3",     32'(rfA3),     32'(eA3));
        checkVal("rf_wd",     rfWd,          eWd);
        checkVal("lng_ready", 32'(lngReady), 32'(eReady));
        checkVal("q_count",   32'(qCount),   32'(mq.size()));
        checkVal("hit1",      32'(hit1),     32'(rst_n && modelHit(chkA1)));
        checkVal("hit2",      32'(hit2),     32'(rst_n && modelHit(chkA2)));
    endtask

    // One full cycle: drive, check, clock edge, advance model
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                                 input logic [4:0] c1, input logic [4:0] c2);
        logic doPop;
        logic doPush;
        aluValid = av; aluRd = ard; aluWd = awd;
        lngValid = lv; lngRd = lrd; lngWd = lwd;
        chkA1 = c1; chkA2 = c2;
        #1;
        checkOutput();
        doPop  = !(av && ard != 5'd0) && (mq.size() > 0);
        doPush = lv && (mq.size() != DEPTH) && (lrd != 5'd0) && !modelBypass();
        @(posedge clk);
        if (doPop) void'(mq.pop_front());
        if (doPush) mq.push_back('{rd: lrd, wd: lwd});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        aluValid = 1'b1; aluRd = 5'd3; aluWd = 32'h1234;
        lngValid = 1'b1; lngRd = 5'd4; lngWd = 32'h55;
        chkA1 = 5'd3; chkA2 = 5'd4;

        // Reset held: no writes, not ready, empty
        @(negedge clk);
        @(negedge clk);
        #1;
        checkVal("rst_rf_wr", 32'(rfWr), 32'd0);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Single push on an idle queue
        applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        aluValid = 0; lngValid = 0;
        #1;
`ifndef WB_BYPASS_EN
        checkVal("push_next_a3", 32'(rfA3), 32'd5);
        checkVal("push_next_wd", rfWd, 32'hDEADBEEF);
`else
        checkVal("bypass_empty_after", 32'(rfWr), 32'd0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Fill behind continuous ALU writes, then drain in order
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 7, 32'h700 + i, 1, 5'(i), 32'hA0 + i, 0, 0);
        applyStimulus(1, 7, 32'h777, 1, 10, 32'hBAD, 2, 3);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);

        // Hazard tracking for a queued rd=9 through its write
        applyStimulus(1, 7, 32'h1, 1, 9, 32'h99, 9, 0);
        applyStimulus(1, 7, 32'h2, 0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);

        // x0 on both sources: no write, nothing enqueued
        applyStimulus(1, 0, 32'hF00D, 1, 0, 32'hBEEF, 0, 0);
        applyStimulus(1, 0, 32'hF00D, 1, 0, 32'hBEEF, 0, 0);

        // Asynchronous reset with three entries queued
        for (int i = 1; i <= 3; i++)
            applyStimulus(1, 7, 32'h10, 1, 5'(i), 32'hC0 + i, 0, 0);
        aluValid = 1; aluRd = 7; lngValid = 0; chkA1 = 1; chkA2 = 2;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        checkVal("arst_count",  32'(qCount),   32'd0);
        checkVal("arst_rf_wr",  32'(rfWr),     32'd0);
        checkVal("arst_ready",  32'(lngReady), 32'd0);
        checkVal("arst_hit1",   32'(hit1),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);

        // Full queue: push refused during a pop, accepted next cycle
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 6, 32'h20, 1, 5'(i + 10), 32'hD0 + i, 0, 0);
        applyStimulus(0, 0, 0, 1, 20, 32'hE0, 20, 11);
        checkVal("full_pop_count", 32'(qCount), 32'd3);
        applyStimulus(0, 0, 0, 1, 20, 32'hE0, 20, 12);
        checkVal("full_accept_count", 32'(qCount), 32'd3);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 20, 0);

        // Randomized traffic with small register ranges for frequent hits
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries in the long-latency write queue; legal values 2, 4, 8.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: alu_valid  in  1  single-cycle ALU result present this cycle; never stalled.
REQ-005 Port: alu_rd  in  5  destination register of the ALU result.
REQ-006 Port: alu_wd  in  32  ALU result data.
REQ-007 Port: lng_valid  in  1  long-latency result (load, mult, div) offered.
REQ-008 Port: lng_ready  out  1  queue can accept a long-latency result this cycle.
REQ-009 Port: lng_rd  in  5  destination register of the long-latency result.
REQ-010 Port: lng_wd  in  32  long-latency result data.
REQ-011 Port: rf_wr  out  1  register-file write enable.
REQ-012 Port: rf_a3  out  5  register-file write address.
REQ-013 Port: rf_wd  out  32  register-file write data.
REQ-014 Port: chk_a1, chk_a2  in  5 each  source registers of the instruction in decode.
REQ-015 Port: hit1, hit2  out  1 each  a queued write is pending to chk_a1 / chk_a2.
REQ-016 Port: q_count  out  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-017 The long-latency queue SHALL be a FIFO of DEPTH {rd, wd} entries with registered head pointer, tail pointer and count; the pointers wrap modulo DEPTH.
REQ-018 lng_ready SHALL equal (count != DEPTH), derived from the registered count only; a push is never accepted when the queue is full, even if a pop occurs in the same cycle.
REQ-019 A transfer SHALL occur when lng_valid && lng_ready; a transfer with lng_rd == 0 is acknowledged and discarded (not enqueued).
REQ-020 Port priority each cycle: if alu_valid && alu_rd != 0, rf_wr=1, rf_a3=alu_rd, rf_wd=alu_wd, and no pop.
REQ-021 Otherwise, if count != 0, rf_wr=1, rf_a3/rf_wd = head entry, and the head is popped at the next posedge.
REQ-022 Otherwise rf_wr=0, rf_a3=0 and rf_wd=0.
REQ-023 alu_valid with alu_rd == 0 SHALL NOT use the write port; the queue may drain in that cycle.
REQ-024 The rf_* outputs SHALL be combinational from the alu_* inputs and the registered queue state; the RF captures them at the posedge.
REQ-025 Latency: an enqueued entry is written no earlier than the cycle after acceptance (see REQ-033) and is delayed one cycle for every ALU write that takes priority.
REQ-026 hit1 SHALL be 1 iff chk_a1 != 0 and some valid queue entry has rd == chk_a1; hit2 is the same for chk_a2.
REQ-027 hit1 and hit2 SHALL NOT include the entry being accepted this cycle; they include the head being popped until that posedge.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-029 WAW ordering between ALU and queued writes is the issuer's responsibility, using hit1/hit2 to stall; this block preserves FIFO order among queued entries.

Reset
REQ-030 While rst_n=0: count=0; head=0; tail=0; lng_ready=0; hit1=hit2=0; q_count=0.
REQ-031 While rst_n=0, rf_wr=0 regardless of alu_valid.
REQ-032 Assertion of rst_n mid-operation SHALL discard all queued entries immediately; lng_ready rises in the first cycle after release.

Configuration
REQ-033 Macro WB_BYPASS_EN: when defined, a transfer in a cycle with count == 0 and no ALU write (per REQ-020) SHALL be written to the RF in the same cycle (rf_wr=1, rf_a3=lng_rd, rf_wd=lng_wd) and is not enqueued.
REQ-034 Without WB_BYPASS_EN, every accepted non-zero transfer SHALL be enqueued, and the earliest write is the following cycle.

Verification
REQ-035 Idle queue; push rd=5, wd=0xDEADBEEF, alu_valid=0 -> rf_wr=1 with a3=5 and wd=0xDEADBEEF in the next cycle; with WB_BYPASS_EN, in the same cycle.
REQ-036 Push 4 entries (DEPTH=4, rd 1..4) while alu_valid=1, alu_rd=7 every cycle -> lng_ready=0 at count=4 and only ALU writes appear; drop alu_valid -> writes rd 1,2,3,4 in order, one per cycle.
REQ-037 Queue holds rd=9; chk_a1=9, chk_a2=0 -> hit1=1, hit2=0; after the rd=9 write, hit1=0 the next cycle.
REQ-038 Push rd=0 and alu_rd=0 with alu_valid=1 -> no rf_wr, count unchanged, lng_ready stays 1.
REQ-039 Queue count=3; assert rst_n=0 asynchronously -> count=0 and rf_wr=0 immediately; release -> lng_ready=1 next cycle, and no stale writes appear.
REQ-040 Full queue with lng_valid=1 and a simultaneous pop -> push refused that cycle, count goes 4->3, and the push is accepted the following cycle.
